// File: rtl/riscv_csr_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, trap causes,
// mstatus field positions and SYSTEM instruction encodings.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MEXT_IRQ_BIT     = 11;

    localparam logic [31:0] CAUSE_MISALIGNED_FETCH = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL_INSN     = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT       = 32'd3;
    localparam logic [31:0] CAUSE_MISALIGNED_LOAD  = 32'd4;
    localparam logic [31:0] CAUSE_LOAD_FAULT       = 32'd5;
    localparam logic [31:0] CAUSE_MISALIGNED_STORE = 32'd6;
    localparam logic [31:0] CAUSE_STORE_FAULT      = 32'd7;
    localparam logic [31:0] CAUSE_ECALL_M          = 32'd11;
    localparam logic [31:0] CAUSE_PAGE_LOAD        = 32'd13;
    localparam logic [31:0] CAUSE_PAGE_STORE       = 32'd15;
    localparam logic [31:0] CAUSE_IRQ_MEXT         = 32'h8000_000B;

    localparam logic [6:0]  OPC_SYSTEM     = 7'b1110011;
    localparam logic [31:0] INSN_ECALL     = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK    = 32'h0010_0073;
    localparam logic [31:0] INSN_MRET      = 32'h3020_0073;
    localparam logic [31:0] INSN_MRET_ALT  = 32'h1020_0073;

    typedef enum logic [2:0] {
        F3_PRIV   = 3'b000,
        F3_CSRRW  = 3'b001,
        F3_CSRRS  = 3'b010,
        F3_CSRRC  = 3'b011,
        F3_RSVD   = 3'b100,
        F3_CSRRWI = 3'b101,
        F3_CSRRSI = 3'b110,
        F3_CSRRCI = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        CSR_OP_RW  = 2'b00,
        CSR_OP_SET = 2'b01,
        CSR_OP_CLR = 2'b10
    } csr_op_e;

    function automatic logic [31:0] csr_apply(input logic [1:0] op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] src);
        logic [31:0] res;
        case (op)
            CSR_OP_RW:  res = src;
            CSR_OP_SET: res = old_val | src;
            CSR_OP_CLR: res = old_val & ~src;
            default:    res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/riscv_csr_regfile.sv
// Machine-mode CSR storage: read mux with implemented/read-only flags,
// read-modify-write commit, trap entry and MRET state updates.
module riscv_csr_regfile
    import riscv_csr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        intr_i,
    input  logic [31:0] cpu_id_i,
    input  logic [31:0] reset_vector_i,
    input  logic [11:0] addr_i,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_op_i,
    input  logic [31:0] wr_src_i,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_epc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        rd_ro_o,
    output logic        irq_pending_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);

    logic        status_mie_q, status_mpie_q, mip_irq_q;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mcycle_q;
    logic [31:0] wdata_s;

    // CSR read mux; anything not listed is an unimplemented address
    always_comb begin
        rd_data_o  = 32'd0;
        rd_valid_o = 1'b1;
        rd_ro_o    = 1'b0;
        case (addr_i)
            CSR_MSTATUS:  rd_data_o = {19'd0, 2'b11, 3'd0, status_mpie_q, 3'd0, status_mie_q, 3'd0};
            CSR_MISA:     begin rd_data_o = MISA_VALUE; rd_ro_o = 1'b1; end
            CSR_MIE:      rd_data_o = mie_q;
            CSR_MTVEC:    rd_data_o = mtvec_q;
            CSR_MSCRATCH: rd_data_o = mscratch_q;
            CSR_MEPC:     rd_data_o = {mepc_q[31:2], 2'b00};
            CSR_MCAUSE:   rd_data_o = mcause_q;
            CSR_MTVAL:    rd_data_o = mtval_q;
            CSR_MIP:      begin rd_data_o = {20'd0, mip_irq_q, 11'd0}; rd_ro_o = 1'b1; end
            CSR_MCYCLE:   rd_data_o = mcycle_q;
            CSR_CYCLE:    begin rd_data_o = mcycle_q; rd_ro_o = 1'b1; end
            CSR_MHARTID:  begin rd_data_o = cpu_id_i; rd_ro_o = 1'b1; end
            default:      rd_valid_o = 1'b0;
        endcase
    end

    assign wdata_s       = csr_apply(wr_op_i, rd_data_o, wr_src_i);
    assign irq_pending_o = status_mie_q & mie_q[MEXT_IRQ_BIT] & mip_irq_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = {mepc_q[31:2], 2'b00};

    // CSR state: trap entry, MRET and software writes are mutually exclusive by construction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            mip_irq_q     <= 1'b0;
            mie_q         <= 32'h0000_0800;
            mtvec_q       <= reset_vector_i;
            mscratch_q    <= 32'd0;
            mepc_q        <= 32'd0;
            mcause_q      <= 32'd0;
            mtval_q       <= 32'd0;
            mcycle_q      <= 32'd0;
        end else begin
            mip_irq_q <= intr_i;
            if (wr_en_i && (addr_i == CSR_MCYCLE)) begin
                mcycle_q <= wdata_s;
            end else begin
                mcycle_q <= mcycle_q + 32'd1;
            end
            if (trap_i) begin
                mepc_q        <= trap_epc_i;
                mcause_q      <= trap_cause_i;
                mtval_q       <= trap_tval_i;
                status_mpie_q <= status_mie_q;
                status_mie_q  <= 1'b0;
            end else if (mret_i) begin
                status_mie_q  <= status_mpie_q;
                status_mpie_q <= 1'b1;
            end else if (wr_en_i) begin
                case (addr_i)
                    CSR_MSTATUS: begin
                        status_mie_q  <= wdata_s[MSTATUS_MIE_BIT];
                        status_mpie_q <= wdata_s[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE:      mie_q      <= wdata_s;
                    CSR_MTVEC:    mtvec_q    <= wdata_s;
                    CSR_MSCRATCH: mscratch_q <= wdata_s;
                    CSR_MEPC:     mepc_q     <= wdata_s;
                    CSR_MCAUSE:   mcause_q   <= wdata_s;
                    CSR_MTVAL:    mtval_q    <= wdata_s;
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: rtl/riscv_csr.sv
// RV32 machine-mode CSR unit: SYSTEM decode, trap/MRET arbitration and
// registered writeback/redirect outputs around the CSR register file.
module riscv_csr
    import riscv_csr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        intr_i,
    input  logic        opcode_valid_i,
    input  logic [57:0] opcode_instr_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_pc_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [4:0]  opcode_ra_idx_i,
    input  logic [4:0]  opcode_rb_idx_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        branch_exec_request_i,
    input  logic [31:0] branch_exec_pc_i,
    input  logic [31:0] cpu_id_i,
    input  logic [31:0] reset_vector_i,
    input  logic        fault_store_i,
    input  logic        fault_load_i,
    input  logic        fault_misaligned_store_i,
    input  logic        fault_misaligned_load_i,
    input  logic        fault_page_store_i,
    input  logic        fault_page_load_i,
    input  logic [31:0] fault_addr_i,
    output logic [4:0]  writeback_idx_o,
    output logic        writeback_squash_o,
    output logic [31:0] writeback_value_o,
    output logic        stall_o,
    output logic        branch_csr_request_o,
    output logic [31:0] branch_csr_pc_o
);

    logic        is_system_s, is_csr_s, csr_wr_s, csr_illegal_s, sys_illegal_s, pc_misaligned_s;
    logic        is_ecall_s, is_ebreak_s, is_mret_s, fault_any_s;
    logic        trap_s, mret_s, csr_commit_s, irq_take_s, irq_pending_s;
    logic        csr_impl_s, csr_ro_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s, rd_s;
    logic [11:0] csr_addr_s;
    logic [1:0]  csr_op_s;
    logic [31:0] csr_src_s, csr_rdata_s, mtvec_s, mepc_s;
    logic [31:0] fault_cause_s, cause_s, tval_s, epc_s, redirect_pc_d;
    logic [31:0] pc_track_q;
    logic        unused_s;

    assign unused_s = ^{opcode_instr_i, opcode_rd_idx_i, opcode_ra_idx_i, opcode_rb_idx_i,
                        opcode_rb_operand_i};

    assign funct3_s   = opcode_opcode_i[14:12];
    assign rs1_s      = opcode_opcode_i[19:15];
    assign rd_s       = opcode_opcode_i[11:7];
    assign csr_addr_s = opcode_opcode_i[31:20];

    // SYSTEM decode; funct3 low bits zero means a privileged word or the reserved encoding
    always_comb begin
        is_system_s     = opcode_valid_i && (opcode_opcode_i[6:0] == OPC_SYSTEM);
        is_csr_s        = is_system_s && (funct3_s[1:0] != 2'b00);
        csr_wr_s        = is_csr_s && ((funct3_s[1:0] == 2'b01) || (rs1_s != 5'd0));
        csr_src_s       = funct3_s[2] ? {27'd0, rs1_s} : opcode_ra_operand_i;
        is_ecall_s      = is_system_s && (opcode_opcode_i == INSN_ECALL);
        is_ebreak_s     = is_system_s && (opcode_opcode_i == INSN_EBREAK);
        is_mret_s       = is_system_s && ((opcode_opcode_i == INSN_MRET) ||
                                          (opcode_opcode_i == INSN_MRET_ALT));
        csr_illegal_s   = is_csr_s && (!csr_impl_s || (csr_wr_s && csr_ro_s));
        sys_illegal_s   = is_system_s && !is_csr_s && !is_ecall_s && !is_ebreak_s && !is_mret_s;
        pc_misaligned_s = opcode_valid_i && (opcode_pc_i[1:0] != 2'b00);
        case (funct3_s[1:0])
            2'b01:   csr_op_s = CSR_OP_RW;
            2'b10:   csr_op_s = CSR_OP_SET;
            2'b11:   csr_op_s = CSR_OP_CLR;
            default: csr_op_s = CSR_OP_RW;
        endcase
    end

    // Simultaneous LSU faults resolve to the lowest cause code
    always_comb begin
        fault_any_s = 1'b1;
        if (fault_misaligned_load_i) begin
            fault_cause_s = CAUSE_MISALIGNED_LOAD;
        end else if (fault_load_i) begin
            fault_cause_s = CAUSE_LOAD_FAULT;
        end else if (fault_misaligned_store_i) begin
            fault_cause_s = CAUSE_MISALIGNED_STORE;
        end else if (fault_store_i) begin
            fault_cause_s = CAUSE_STORE_FAULT;
        end else if (fault_page_load_i) begin
            fault_cause_s = CAUSE_PAGE_LOAD;
        end else if (fault_page_store_i) begin
            fault_cause_s = CAUSE_PAGE_STORE;
        end else begin
            fault_cause_s = 32'd0;
            fault_any_s   = 1'b0;
        end
    end

    // Event arbitration: fault > interrupt > instruction exception > MRET > CSR op
    always_comb begin
        trap_s       = 1'b1;
        irq_take_s   = 1'b0;
        mret_s       = 1'b0;
        csr_commit_s = 1'b0;
        cause_s      = 32'd0;
        tval_s       = 32'd0;
        epc_s        = opcode_pc_i;
        if (fault_any_s) begin
            cause_s = fault_cause_s;
            tval_s  = fault_addr_i;
        end else if (irq_pending_s) begin
            irq_take_s = 1'b1;
            cause_s    = CAUSE_IRQ_MEXT;
            epc_s      = pc_track_q;
        end else if (pc_misaligned_s) begin
            cause_s = CAUSE_MISALIGNED_FETCH;
            tval_s  = opcode_pc_i;
        end else if (csr_illegal_s || sys_illegal_s) begin
            cause_s = CAUSE_ILLEGAL_INSN;
            tval_s  = opcode_opcode_i;
        end else if (is_ecall_s) begin
            cause_s = CAUSE_ECALL_M;
        end else if (is_ebreak_s) begin
            cause_s = CAUSE_BREAKPOINT;
        end else begin
            trap_s       = 1'b0;
            mret_s       = is_mret_s;
            csr_commit_s = is_csr_s;
        end
    end

    // Redirect target; vectored mode offsets only interrupts
    always_comb begin
        if (trap_s && irq_take_s && mtvec_s[0]) begin
            redirect_pc_d = {mtvec_s[31:2], 2'b00} + {cause_s[29:0], 2'b00};
        end else if (trap_s) begin
            redirect_pc_d = {mtvec_s[31:2], 2'b00};
        end else if (mret_s) begin
            redirect_pc_d = mepc_s;
        end else begin
            redirect_pc_d = 32'd0;
        end
    end

    riscv_csr_regfile u_regfile (
        .clk_i          (clk_i),
        .rst_ni         (rst_i),
        .intr_i         (intr_i),
        .cpu_id_i       (cpu_id_i),
        .reset_vector_i (reset_vector_i),
        .addr_i         (csr_addr_s),
        .wr_en_i        (csr_commit_s && csr_wr_s),
        .wr_op_i        (csr_op_s),
        .wr_src_i       (csr_src_s),
        .trap_i         (trap_s),
        .trap_cause_i   (cause_s),
        .trap_epc_i     (epc_s),
        .trap_tval_i    (tval_s),
        .mret_i         (mret_s),
        .rd_data_o      (csr_rdata_s),
        .rd_valid_o     (csr_impl_s),
        .rd_ro_o        (csr_ro_s),
        .irq_pending_o  (irq_pending_s),
        .mtvec_o        (mtvec_s),
        .mepc_o         (mepc_s)
    );

    // Registered pipeline outputs and the PC used as the interrupt return address
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            writeback_idx_o      <= 5'd0;
            writeback_value_o    <= 32'd0;
            writeback_squash_o   <= 1'b0;
            stall_o              <= 1'b0;
            branch_csr_request_o <= 1'b0;
            branch_csr_pc_o      <= 32'd0;
            pc_track_q           <= 32'd0;
        end else begin
            writeback_idx_o      <= csr_commit_s ? rd_s : 5'd0;
            writeback_value_o    <= csr_commit_s ? csr_rdata_s : 32'd0;
            writeback_squash_o   <= trap_s | mret_s;
            stall_o              <= trap_s | mret_s;
            branch_csr_request_o <= trap_s | mret_s;
            branch_csr_pc_o      <= redirect_pc_d;
            if (branch_exec_request_i) begin
                pc_track_q <= branch_exec_pc_i;
            end else if (opcode_valid_i) begin
                pc_track_q <= opcode_pc_i + 32'd4;
            end else begin
                pc_track_q <= pc_track_q;
            end
        end
    end

endmodule

// File: tb/tb_riscv_csr.sv
// Directed self-checking bench for riscv_csr: one task per feature, inline
// comparisons against hand-computed values.
module tb_riscv_csr;

    logic        clk_i = 1'b0, rst_i = 1'b0, intr_i = 1'b0, opcode_valid_i = 1'b0;
    logic [57:0] opcode_instr_i = 58'd0;
    logic [31:0] opcode_opcode_i = 32'd0, opcode_pc_i = 32'd0;
    logic [4:0]  opcode_rd_idx_i = 5'd0, opcode_ra_idx_i = 5'd0, opcode_rb_idx_i = 5'd0;
    logic [31:0] opcode_ra_operand_i = 32'd0, opcode_rb_operand_i = 32'd0;
    logic        branch_exec_request_i = 1'b0;
    logic [31:0] branch_exec_pc_i = 32'd0;
    logic [31:0] cpu_id_i = 32'h0000_0005, reset_vector_i = 32'h0000_0100;
    logic        fault_store_i = 1'b0, fault_load_i = 1'b0, fault_misaligned_store_i = 1'b0;
    logic        fault_misaligned_load_i = 1'b0, fault_page_store_i = 1'b0, fault_page_load_i = 1'b0;
    logic [31:0] fault_addr_i = 32'd0;
    logic [4:0]  writeback_idx_o;
    logic        writeback_squash_o, stall_o, branch_csr_request_o;
    logic [31:0] writeback_value_o, branch_csr_pc_o;

    int          checks = 0, failures = 0;
    logic [31:0] tb_pc = 32'h0000_0200;
    logic [31:0] rv, rv2;

    riscv_csr dut (
        .clk_i(clk_i), .rst_i(rst_i), .intr_i(intr_i),
        .opcode_valid_i(opcode_valid_i), .opcode_instr_i(opcode_instr_i),
        .opcode_opcode_i(opcode_opcode_i), .opcode_pc_i(opcode_pc_i),
        .opcode_rd_idx_i(opcode_rd_idx_i), .opcode_ra_idx_i(opcode_ra_idx_i),
        .opcode_rb_idx_i(opcode_rb_idx_i), .opcode_ra_operand_i(opcode_ra_operand_i),
        .opcode_rb_operand_i(opcode_rb_operand_i),
        .branch_exec_request_i(branch_exec_request_i), .branch_exec_pc_i(branch_exec_pc_i),
        .cpu_id_i(cpu_id_i), .reset_vector_i(reset_vector_i),
        .fault_store_i(fault_store_i), .fault_load_i(fault_load_i),
        .fault_misaligned_store_i(fault_misaligned_store_i),
        .fault_misaligned_load_i(fault_misaligned_load_i),
        .fault_page_store_i(fault_page_store_i), .fault_page_load_i(fault_page_load_i),
        .fault_addr_i(fault_addr_i),
        .writeback_idx_o(writeback_idx_o), .writeback_squash_o(writeback_squash_o),
        .writeback_value_o(writeback_value_o), .stall_o(stall_o),
        .branch_csr_request_o(branch_csr_request_o), .branch_csr_pc_o(branch_csr_pc_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] csr_insn(input logic [2:0] f3, input logic [11:0] addr,
                                             input logic [4:0] rs1, input logic [4:0] rd);
        return {addr, rs1, f3, rd, 7'b1110011};
    endfunction

    task automatic idle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] op, input logic [31:0] pc, input logic [31:0] ra);
        opcode_valid_i      = 1'b1;
        opcode_opcode_i     = op;
        opcode_pc_i         = pc;
        opcode_ra_operand_i = ra;
        opcode_rd_idx_i     = op[11:7];
        opcode_ra_idx_i     = op[19:15];
        idle();
        opcode_valid_i  = 1'b0;
        opcode_opcode_i = 32'd0;
    endtask

    task automatic exec(input logic [31:0] op, input logic [31:0] ra);
        issue(op, tb_pc, ra);
        tb_pc = tb_pc + 32'd4;
    endtask

    task automatic read_csr(input logic [11:0] addr, output logic [31:0] val);
        exec(csr_insn(3'b010, addr, 5'd0, 5'd1), 32'd0);
        val = writeback_value_o;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({branch_csr_request_o, stall_o, writeback_squash_o, writeback_idx_o, branch_csr_pc_o, writeback_value_o} !== 72'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {branch_csr_request_o, stall_o, writeback_squash_o, writeback_idx_o, branch_csr_pc_o, writeback_value_o});
        end
        rst_i = 1'b1;
        read_csr(12'h300, rv);
        checks++; if (rv !== 32'h0000_1800) begin failures++; $display("FAIL reset_mstatus got=%h exp=%h", rv, 32'h1800); end
        checks++; if (writeback_idx_o !== 5'd1 || writeback_squash_o !== 1'b0) begin failures++; $display("FAIL read_wb idx=%0d squash=%b exp idx=1 squash=0", writeback_idx_o, writeback_squash_o); end
        read_csr(12'h304, rv);
        checks++; if (rv !== 32'h0000_0800) begin failures++; $display("FAIL reset_mie got=%h exp=%h", rv, 32'h800); end
        read_csr(12'h305, rv);
        checks++; if (rv !== 32'h0000_0100) begin failures++; $display("FAIL reset_mtvec got=%h exp=%h", rv, 32'h100); end
        read_csr(12'h301, rv);
        checks++; if (rv !== 32'h4000_0100) begin failures++; $display("FAIL misa got=%h exp=%h", rv, 32'h40000100); end
        read_csr(12'hF14, rv);
        checks++; if (rv !== 32'h0000_0005) begin failures++; $display("FAIL mhartid got=%h exp=%h", rv, 32'h5); end
        read_csr(12'h341, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL reset_mepc got=%h exp=0", rv); end
        read_csr(12'hB00, rv);
        read_csr(12'hC00, rv2);
        checks++; if (rv2 - rv !== 32'd1) begin failures++; $display("FAIL mcycle_step got=%h exp=%h", rv2 - rv, 32'd1); end
    endtask

    task automatic test_ecall();
        issue(32'h0000_0073, 32'h0000_1004, 32'd0);
        checks++;
        if ({branch_csr_request_o, stall_o, writeback_squash_o, writeback_idx_o, branch_csr_pc_o} !== {3'b111, 5'd0, 32'h100}) begin
            failures++; $display("FAIL ecall_redirect req=%b stall=%b squash=%b idx=%0d pc=%h exp 1 1 1 0 00000100", branch_csr_request_o, stall_o, writeback_squash_o, writeback_idx_o, branch_csr_pc_o);
        end
        idle();
        checks++; if ({branch_csr_request_o, stall_o, writeback_squash_o} !== 3'b000) begin failures++; $display("FAIL redirect_one_cycle got=%b exp=000", {branch_csr_request_o, stall_o, writeback_squash_o}); end
        exec(csr_insn(3'b001, 12'h342, 5'd0, 5'd2), 32'd0);
        checks++; if (writeback_idx_o !== 5'd2 || writeback_value_o !== 32'd11) begin failures++; $display("FAIL ecall_mcause idx=%0d got=%h exp idx=2 val=0000000b", writeback_idx_o, writeback_value_o); end
        read_csr(12'h341, rv);
        checks++; if (rv !== 32'h0000_1004) begin failures++; $display("FAIL ecall_mepc got=%h exp=%h", rv, 32'h1004); end
    endtask

    task automatic test_mret();
        exec(csr_insn(3'b110, 12'h300, 5'd8, 5'd0), 32'd0);
        issue(32'h0000_0073, 32'h0000_1004, 32'd0);
        read_csr(12'h300, rv);
        checks++; if (rv !== 32'h0000_1880) begin failures++; $display("FAIL trap_mstatus got=%h exp=%h", rv, 32'h1880); end
        issue(32'h3020_0073, 32'h0000_2000, 32'd0);
        checks++; if (branch_csr_request_o !== 1'b1 || branch_csr_pc_o !== 32'h0000_1004) begin failures++; $display("FAIL mret_target req=%b got=%h exp=%h", branch_csr_request_o, branch_csr_pc_o, 32'h1004); end
        read_csr(12'h300, rv);
        checks++; if (rv !== 32'h0000_1888) begin failures++; $display("FAIL mret_mstatus got=%h exp=%h", rv, 32'h1888); end
        issue(32'h1020_0073, 32'h0000_2004, 32'd0);
        checks++; if (branch_csr_request_o !== 1'b1 || branch_csr_pc_o !== 32'h0000_1004) begin failures++; $display("FAIL mret_alt req=%b got=%h exp=%h", branch_csr_request_o, branch_csr_pc_o, 32'h1004); end
    endtask

    task automatic test_set_clear();
        exec(csr_insn(3'b011, 12'h300, 5'd1, 5'd0), 32'h0000_0088);
        exec(csr_insn(3'b010, 12'h300, 5'd1, 5'd3), 32'h0000_000F);
        checks++; if (writeback_idx_o !== 5'd3 || writeback_value_o !== 32'h0000_1800) begin failures++; $display("FAIL csrrs_old idx=%0d got=%h exp=%h", writeback_idx_o, writeback_value_o, 32'h1800); end
        exec(csr_insn(3'b011, 12'h300, 5'd1, 5'd4), 32'h0000_000F);
        checks++; if (writeback_value_o !== 32'h0000_1808) begin failures++; $display("FAIL csrrc_old got=%h exp=%h", writeback_value_o, 32'h1808); end
        read_csr(12'h300, rv);
        checks++; if (rv !== 32'h0000_1800) begin failures++; $display("FAIL mstatus_restored got=%h exp=%h", rv, 32'h1800); end
    endtask

    task automatic test_illegal();
        logic [31:0] ill;
        ill = csr_insn(3'b001, 12'h301, 5'd2, 5'd6);
        exec(ill, 32'h1234_5678);
        checks++;
        if ({writeback_squash_o, branch_csr_request_o, writeback_idx_o, branch_csr_pc_o} !== {2'b11, 5'd0, 32'h100}) begin
            failures++; $display("FAIL ro_write squash=%b req=%b idx=%0d pc=%h exp 1 1 0 00000100", writeback_squash_o, branch_csr_request_o, writeback_idx_o, branch_csr_pc_o);
        end
        read_csr(12'h342, rv);
        checks++; if (rv !== 32'd2) begin failures++; $display("FAIL illegal_mcause got=%h exp=%h", rv, 32'd2); end
        read_csr(12'h343, rv);
        checks++; if (rv !== ill) begin failures++; $display("FAIL illegal_mtval got=%h exp=%h", rv, ill); end
        read_csr(12'h301, rv);
        checks++; if (rv !== 32'h4000_0100) begin failures++; $display("FAIL misa_unchanged got=%h exp=%h", rv, 32'h40000100); end
        exec(csr_insn(3'b110, 12'hF14, 5'd0, 5'd9), 32'd0);
        checks++; if (writeback_squash_o !== 1'b0 || writeback_value_o !== 32'd5) begin failures++; $display("FAIL rsi_zero_ro squash=%b got=%h exp 0 00000005", writeback_squash_o, writeback_value_o); end
        exec(csr_insn(3'b010, 12'h7C0, 5'd0, 5'd1), 32'd0);
        checks++; if (writeback_squash_o !== 1'b1 || writeback_idx_o !== 5'd0) begin failures++; $display("FAIL unimpl_csr squash=%b idx=%0d exp 1 0", writeback_squash_o, writeback_idx_o); end
        exec(csr_insn(3'b101, 12'hC00, 5'd3, 5'd1), 32'd0);
        checks++; if (writeback_squash_o !== 1'b1) begin failures++; $display("FAIL cycle_write squash=%b exp=1", writeback_squash_o); end
        exec(32'h1050_0073, 32'd0);
        read_csr(12'h342, rv);
        checks++; if (rv !== 32'd2) begin failures++; $display("FAIL wfi_illegal got=%h exp=%h", rv, 32'd2); end
    endtask

    task automatic test_misaligned_pc();
        issue(32'h0000_0013, 32'h0000_1002, 32'd0);
        checks++; if (branch_csr_request_o !== 1'b1 || branch_csr_pc_o !== 32'h100) begin failures++; $display("FAIL misalign_redirect req=%b pc=%h exp 1 00000100", branch_csr_request_o, branch_csr_pc_o); end
        read_csr(12'h342, rv);
        checks++; if (rv !== 32'd0) begin failures++; $display("FAIL misalign_mcause got=%h exp=0", rv); end
        read_csr(12'h343, rv);
        checks++; if (rv !== 32'h0000_1002) begin failures++; $display("FAIL misalign_mtval got=%h exp=%h", rv, 32'h1002); end
        read_csr(12'h341, rv);
        checks++; if (rv !== 32'h0000_1000) begin failures++; $display("FAIL mepc_low_bits got=%h exp=%h", rv, 32'h1000); end
    endtask

    task automatic test_back_to_back();
        exec(csr_insn(3'b001, 12'h340, 5'd1, 5'd5), 32'hDEAD_BEEF);
        checks++; if (writeback_idx_o !== 5'd5 || writeback_value_o !== 32'd0) begin failures++; $display("FAIL b2b_first idx=%0d got=%h exp 5 00000000", writeback_idx_o, writeback_value_o); end
        exec(csr_insn(3'b101, 12'h340, 5'h1F, 5'd6), 32'd0);
        checks++; if (writeback_idx_o !== 5'd6 || writeback_value_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_second idx=%0d got=%h exp 6 deadbeef", writeback_idx_o, writeback_value_o); end
        read_csr(12'h340, rv);
        checks++; if (rv !== 32'h0000_001F) begin failures++; $display("FAIL mscratch_zimm got=%h exp=%h", rv, 32'h1F); end
    endtask

    task automatic test_interrupt();
        exec(csr_insn(3'b110, 12'h300, 5'd8, 5'd0), 32'd0);
        branch_exec_request_i = 1'b1; branch_exec_pc_i = 32'h0000_3000;
        idle();
        branch_exec_request_i = 1'b0;
        intr_i = 1'b1;
        idle();
        intr_i = 1'b0;
        checks++; if (branch_csr_request_o !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", branch_csr_request_o); end
        idle();
        checks++; if (branch_csr_request_o !== 1'b1 || branch_csr_pc_o !== 32'h100) begin failures++; $display("FAIL irq_redirect req=%b pc=%h exp 1 00000100", branch_csr_request_o, branch_csr_pc_o); end
        read_csr(12'h342, rv);
        checks++; if (rv !== 32'h8000_000B) begin failures++; $display("FAIL irq_mcause got=%h exp=%h", rv, 32'h8000000B); end
        read_csr(12'h341, rv);
        checks++; if (rv !== 32'h0000_3000) begin failures++; $display("FAIL irq_mepc got=%h exp=%h", rv, 32'h3000); end
        read_csr(12'h300, rv);
        checks++; if (rv !== 32'h0000_1880) begin failures++; $display("FAIL irq_mstatus got=%h exp=%h", rv, 32'h1880); end
        read_csr(12'h343, rv);
        checks++; if (rv !== 32'd0) begin failures++; $display("FAIL irq_mtval got=%h exp=0", rv); end
        exec(csr_insn(3'b001, 12'h305, 5'd1, 5'd0), 32'h0000_0101);
        exec(csr_insn(3'b110, 12'h300, 5'd8, 5'd0), 32'd0);
        intr_i = 1'b1;
        idle();
        intr_i = 1'b0;
        idle();
        checks++; if (branch_csr_request_o !== 1'b1 || branch_csr_pc_o !== 32'h0000_012C) begin failures++; $display("FAIL irq_vectored req=%b pc=%h exp 1 0000012c", branch_csr_request_o, branch_csr_pc_o); end
        exec(csr_insn(3'b001, 12'h305, 5'd1, 5'd0), 32'h0000_0100);
    endtask

    task automatic test_faults();
        logic [5:0]  vec [7];
        logic [31:0] exp_cause [7];
        vec = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b101000};
        exp_cause = '{32'd4, 32'd5, 32'd6, 32'd7, 32'd13, 32'd15, 32'd7};
        fault_addr_i = 32'h0000_0040;
        for (int i = 0; i < 7; i++) begin
            {fault_page_store_i, fault_page_load_i, fault_store_i, fault_misaligned_store_i, fault_load_i, fault_misaligned_load_i} = vec[i];
            idle();
            {fault_page_store_i, fault_page_load_i, fault_store_i, fault_misaligned_store_i, fault_load_i, fault_misaligned_load_i} = 6'd0;
            checks++; if (branch_csr_request_o !== 1'b1) begin failures++; $display("FAIL fault_redirect[%0d] got=%b exp=1", i, branch_csr_request_o); end
            read_csr(12'h342, rv);
            checks++; if (rv !== exp_cause[i]) begin failures++; $display("FAIL fault_mcause[%0d] got=%h exp=%h", i, rv, exp_cause[i]); end
            read_csr(12'h343, rv);
            checks++; if (rv !== 32'h0000_0040) begin failures++; $display("FAIL fault_mtval[%0d] got=%h exp=%h", i, rv, 32'h40); end
        end
        exec(csr_insn(3'b110, 12'h300, 5'd8, 5'd0), 32'd0);
        intr_i = 1'b1;
        idle();
        intr_i = 1'b0;
        fault_load_i = 1'b1;
        idle();
        fault_load_i = 1'b0;
        read_csr(12'h342, rv);
        checks++; if (rv !== 32'd5) begin failures++; $display("FAIL fault_beats_irq got=%h exp=%h", rv, 32'd5); end
        fault_store_i = 1'b1;
        exec(csr_insn(3'b001, 12'h340, 5'd1, 5'd7), 32'h0000_1234);
        fault_store_i = 1'b0;
        checks++; if (writeback_idx_o !== 5'd0 || branch_csr_request_o !== 1'b1) begin failures++; $display("FAIL fault_squash_csr idx=%0d req=%b exp 0 1", writeback_idx_o, branch_csr_request_o); end
        read_csr(12'h340, rv);
        checks++; if (rv !== 32'h0000_001F) begin failures++; $display("FAIL fault_no_side_effect got=%h exp=%h", rv, 32'h1F); end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_set_clear();
        test_illegal();
        test_misaligned_pc();
        test_back_to_back();
        test_interrupt();
        test_faults();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
